// File: rtl/scr1_ahb_dmem_ram_pkg.sv
// Shared AHB / data-memory definitions.
// Holds the AHB HTRANS/HSIZE/HRESP encodings and the state enum of the
// AHB data-memory RAM slave, so that both the RTL and benches can use them.
package scr1_ahb_dmem_ram_pkg;

  localparam int SCR1_AHB_WIDTH = 32;

  localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SCR1_HSIZE_8B  = 3'b000;
  localparam logic [2:0] SCR1_HSIZE_16B = 3'b001;
  localparam logic [2:0] SCR1_HSIZE_32B = 3'b010;

  localparam logic SCR1_HRESP_OKAY  = 1'b0;
  localparam logic SCR1_HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    SCR1_AHB_RAM_IDLE   = 3'd0,
    SCR1_AHB_RAM_RD     = 3'd1,
    SCR1_AHB_RAM_WR     = 3'd2,
    SCR1_AHB_RAM_RD_DLY = 3'd3,
    SCR1_AHB_RAM_ERR1   = 3'd4,
    SCR1_AHB_RAM_ERR2   = 3'd5
  } type_scr1_ahb_ram_fsm_e;

endpackage

// File: rtl/scr1_ahb_dmem_ram_chk.sv
// State-legality checker for scr1_ahb_dmem_ram.
// Ports: clk, rst_n, state (current FSM state of the slave).
module scr1_ahb_dmem_ram_chk
  import scr1_ahb_dmem_ram_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  input type_scr1_ahb_ram_fsm_e state
);

  a_state_legal: assert property (
    @(posedge clk) disable iff (!rst_n)
      state inside {SCR1_AHB_RAM_IDLE, SCR1_AHB_RAM_RD, SCR1_AHB_RAM_WR,
                    SCR1_AHB_RAM_RD_DLY, SCR1_AHB_RAM_ERR1, SCR1_AHB_RAM_ERR2}
  );

endmodule

// File: rtl/scr1_sram_sp.sv
// Behavioural single-port synchronous RAM, 32-bit words with byte enables.
// Ports: clk, rst_n, ce (access strobe), we (1 = write), be (byte enables),
//        addr (word address), wdata, rdata (valid the cycle after a ce read).
module scr1_sram_sp #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int DEPTH = 1 << AW;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-masked write port; the array itself has no reset.
  always_ff @(posedge clk) begin
    if (ce && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read data, updated only by a read access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0000_0000;
    end else if (ce && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/scr1_ahb_dmem_ram.sv
// AHB-Lite slave terminating the data-memory bus onto a single-port SRAM.
// Reads complete with zero wait states; a read whose address phase overlaps
// a write data phase costs one wait state; illegal transfers get a
// two-cycle ERROR response and never touch the SRAM.
// Ports:
//   clk, rst_n                          - clock, async active-low reset
//   hsel, htrans, hsize, haddr, hwrite  - AHB address phase
//   hwdata                              - AHB write data (data phase)
//   hprot, hburst, hmastlock            - accepted and ignored
//   hready, hresp, hrdata               - AHB response
//   sram_ce/we/be/addr/wdata, sram_rdata - SRAM port
module scr1_ahb_dmem_ram
  import scr1_ahb_dmem_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_SIZE  = 65536,
  parameter int          SRAM_AW   = $clog2(MEM_SIZE) - 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hsel,
  input  logic [1:0]                htrans,
  input  logic [2:0]                hsize,
  input  logic [SCR1_AHB_WIDTH-1:0] haddr,
  input  logic                      hwrite,
  input  logic [SCR1_AHB_WIDTH-1:0] hwdata,
  input  logic [3:0]                hprot,
  input  logic [2:0]                hburst,
  input  logic                      hmastlock,
  output logic                      hready,
  output logic                      hresp,
  output logic [SCR1_AHB_WIDTH-1:0] hrdata,
  output logic                      sram_ce,
  output logic                      sram_we,
  output logic [3:0]                sram_be,
  output logic [SRAM_AW-1:0]        sram_addr,
  output logic [31:0]               sram_wdata,
  input  logic [31:0]               sram_rdata
);

  localparam logic [31:0] MEM_SIZE_W = 32'(MEM_SIZE);

  // Offset is relative to the MEM_SIZE-aligned base, so its low bits equal haddr's.
  function automatic logic ahb_xfer_err(input logic [31:0] offs, input logic [2:0] size);
    logic err;
    if (offs >= MEM_SIZE_W) begin
      err = 1'b1;
    end else begin
      case (size)
        SCR1_HSIZE_8B : err = 1'b0;
        SCR1_HSIZE_16B: err = offs[0];
        SCR1_HSIZE_32B: err = |offs[1:0];
        default       : err = 1'b1;
      endcase
    end
    return err;
  endfunction

  function automatic logic [3:0] ahb_byte_en(input logic [1:0] a, input logic [2:0] size);
    logic [3:0] be;
    case (size)
      SCR1_HSIZE_8B : be = 4'b0001 << a;
      SCR1_HSIZE_16B: be = 4'b0011 << {a[1], 1'b0};
      SCR1_HSIZE_32B: be = 4'b1111;
      default       : be = 4'b0000;
    endcase
    return be;
  endfunction

  type_scr1_ahb_ram_fsm_e state_q, state_d;
  logic [SRAM_AW-1:0]     addr_q, addr_d;
  logic [3:0]             be_q, be_d;

  logic [31:0]        offs_s;
  logic [SRAM_AW-1:0] word_s;
  logic [3:0]         be_s;
  logic               err_s;
  logic               req_s;
  logic               rd_issue_s;
  logic               unused_s;

  // req_s ignores hready: it is only consulted in states that drive hready=1.
  // Gating with rst_n keeps the SRAM strobe low while reset is asserted.
  assign offs_s     = haddr - BASE_ADDR;
  assign word_s     = offs_s[SRAM_AW+1:2];
  assign be_s       = ahb_byte_en(offs_s[1:0], hsize);
  assign err_s      = ahb_xfer_err(offs_s, hsize);
  assign req_s      = rst_n & hsel & ((htrans == SCR1_HTRANS_NONSEQ) | (htrans == SCR1_HTRANS_SEQ));
  assign rd_issue_s = req_s & ~err_s & ~hwrite;
  assign unused_s   = ^{hprot, hburst, hmastlock};

  // State and latched write/read word address + byte enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCR1_AHB_RAM_IDLE;
      addr_q  <= {SRAM_AW{1'b0}};
      be_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end

  // Next-state logic and address latching.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    case (state_q)
      SCR1_AHB_RAM_IDLE, SCR1_AHB_RAM_RD, SCR1_AHB_RAM_ERR2: begin
        if (!req_s) begin
          state_d = SCR1_AHB_RAM_IDLE;
        end else if (err_s) begin
          state_d = SCR1_AHB_RAM_ERR1;
        end else if (hwrite) begin
          state_d = SCR1_AHB_RAM_WR;
          addr_d  = word_s;
          be_d    = be_s;
        end else begin
          state_d = SCR1_AHB_RAM_RD;
        end
      end
      SCR1_AHB_RAM_WR: begin
        if (!req_s) begin
          state_d = SCR1_AHB_RAM_IDLE;
        end else if (err_s) begin
          state_d = SCR1_AHB_RAM_ERR1;
        end else begin
          // The SRAM port is busy with this write, so a read is deferred one cycle.
          addr_d  = word_s;
          be_d    = be_s;
          state_d = hwrite ? SCR1_AHB_RAM_WR : SCR1_AHB_RAM_RD_DLY;
        end
      end
      SCR1_AHB_RAM_RD_DLY: state_d = SCR1_AHB_RAM_RD;
      SCR1_AHB_RAM_ERR1  : state_d = SCR1_AHB_RAM_ERR2;
      default            : state_d = SCR1_AHB_RAM_IDLE;
    endcase
  end

  // AHB response and SRAM strobes.
  always_comb begin
    hready     = 1'b1;
    hresp      = SCR1_HRESP_OKAY;
    hrdata     = {SCR1_AHB_WIDTH{1'b0}};
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 4'b0000;
    sram_addr  = {SRAM_AW{1'b0}};
    sram_wdata = hwdata;
    case (state_q)
      SCR1_AHB_RAM_IDLE, SCR1_AHB_RAM_RD, SCR1_AHB_RAM_ERR2: begin
        if (state_q == SCR1_AHB_RAM_ERR2) begin
          hresp = SCR1_HRESP_ERROR;
        end else begin
          hresp = SCR1_HRESP_OKAY;
        end
        if (state_q == SCR1_AHB_RAM_RD) begin
          hrdata = sram_rdata;
        end else begin
          hrdata = {SCR1_AHB_WIDTH{1'b0}};
        end
        // Reads go to the SRAM in their address phase for zero-wait data.
        if (rd_issue_s) begin
          sram_ce   = 1'b1;
          sram_be   = be_s;
          sram_addr = word_s;
        end else begin
          sram_ce   = 1'b0;
          sram_be   = 4'b0000;
          sram_addr = {SRAM_AW{1'b0}};
        end
      end
      SCR1_AHB_RAM_WR: begin
        sram_ce   = 1'b1;
        sram_we   = 1'b1;
        sram_be   = be_q;
        sram_addr = addr_q;
      end
      SCR1_AHB_RAM_RD_DLY: begin
        hready    = 1'b0;
        sram_ce   = 1'b1;
        sram_be   = be_q;
        sram_addr = addr_q;
      end
      SCR1_AHB_RAM_ERR1: begin
        hready = 1'b0;
        hresp  = SCR1_HRESP_ERROR;
      end
      default: begin
        hready     = 1'bx;
        hresp      = 1'bx;
        hrdata     = {SCR1_AHB_WIDTH{1'bx}};
        sram_ce    = 1'bx;
        sram_we    = 1'bx;
        sram_be    = 4'bxxxx;
        sram_addr  = {SRAM_AW{1'bx}};
        sram_wdata = 32'hxxxx_xxxx;
      end
    endcase
  end

  scr1_ahb_dmem_ram_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .state (state_q)
  );

endmodule

// File: tb/tb_scr1_ahb_dmem_ram.sv
module tb_scr1_ahb_dmem_ram;
  import scr1_ahb_dmem_ram_pkg::*;

  localparam int MEM_SIZE = 65536;
  localparam int AW       = 14;
  localparam int MAXN     = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready, hresp;
  logic [31:0] hrdata;
  logic        sram_ce, sram_we;
  logic [3:0]  sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  scr1_ahb_dmem_ram #(.BASE_ADDR(32'h0000_0000), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .hsel(hsel), .htrans(htrans), .hsize(hsize),
    .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hprot(4'b0011),
    .hburst(3'b000), .hmastlock(1'b0), .hready(hready), .hresp(hresp),
    .hrdata(hrdata), .sram_ce(sram_ce), .sram_we(sram_we), .sram_be(sram_be),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  scr1_sram_sp #(.AW(AW)) u_ram (
    .clk(clk), .rst_n(rst_n), .ce(sram_ce), .we(sram_we), .be(sram_be),
    .addr(sram_addr), .wdata(sram_wdata), .rdata(sram_rdata)
  );

  int checks = 0;
  int errors = 0;

  // transfer table, observed results, expected results
  logic [31:0] xf_addr [MAXN];
  logic [2:0]  xf_size [MAXN];
  logic        xf_write[MAXN];
  logic [31:0] xf_wdata[MAXN];
  logic        xf_gap  [MAXN];
  logic [31:0] res_rdata[MAXN];
  logic        res_resp [MAXN];
  int          res_waits[MAXN];
  logic        res_wresp[MAXN];
  logic        exp_err  [MAXN];
  int          exp_waits[MAXN];
  logic [31:0] exp_rdata[MAXN];
  logic        exp_known[MAXN];

  // reference memory: word index -> fully known word contents
  logic [31:0] mdl [int];

  // SRAM activity seen by the monitor inside run_xfers
  logic [AW-1:0] rd_issue_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [3:0]    wr_be_q[$];

  task automatic set_xf(input int i, input logic [31:0] a, input logic [2:0] s,
                        input logic w, input logic [31:0] d, input logic g);
    xf_addr[i] = a; xf_size[i] = s; xf_write[i] = w; xf_wdata[i] = d; xf_gap[i] = g;
  endtask

  task automatic clear_mon();
    rd_issue_q.delete(); wr_addr_q.delete(); wr_be_q.delete();
  endtask

  // Reference model: AHB rules applied transfer by transfer in program order.
  task automatic predict(input int n);
    int nb, w, first;
    bit prev_wr;
    logic [31:0] tmp;
    prev_wr = 1'b0;
    for (int i = 0; i < n; i++) begin
      nb = 1 << xf_size[i];
      exp_err[i] = (xf_addr[i] >= MEM_SIZE) || (xf_size[i] > 3'd2) || ((xf_addr[i] % nb) != 0);
      w = int'(xf_addr[i] >> 2);
      if (exp_err[i]) exp_waits[i] = 1;
      else if (!xf_write[i] && prev_wr && !xf_gap[i]) exp_waits[i] = 1;
      else exp_waits[i] = 0;
      exp_rdata[i] = 32'h0;
      exp_known[i] = 1'b1;
      if (!exp_err[i] && !xf_write[i]) begin
        if (mdl.exists(w)) exp_rdata[i] = mdl[w];
        else exp_known[i] = 1'b0;
      end
      if (!exp_err[i] && xf_write[i]) begin
        if (nb == 4) mdl[w] = xf_wdata[i];
        else if (mdl.exists(w)) begin
          tmp = mdl[w];
          first = int'(xf_addr[i] % 4);
          for (int k = first; k < first + nb; k++) tmp[8*k +: 8] = xf_wdata[i][8*k +: 8];
          mdl[w] = tmp;
        end
      end
      prev_wr = !exp_err[i] && xf_write[i];
    end
  endtask

  // Pipelined AHB master: address phase of the next transfer overlaps the data phase of the current one.
  task automatic run_xfers(input int n);
    int ap, dp, cyc, wcnt;
    bit presented, gap_done;
    logic wresp;
    ap = 0; dp = -1; cyc = 0; wcnt = 0; wresp = 1'b0; gap_done = 1'b0;
    while ((ap < n || dp >= 0) && cyc < 4000) begin
      @(posedge clk); #1;
      presented = (ap < n) && (!xf_gap[ap] || gap_done);
      if (presented) begin
        hsel = 1'b1; htrans = SCR1_HTRANS_NONSEQ; haddr = xf_addr[ap];
        hsize = xf_size[ap]; hwrite = xf_write[ap];
      end else begin
        hsel = 1'($urandom_range(0, 1)); htrans = 2'($urandom_range(0, 1));
        haddr = $urandom; hsize = 3'($urandom_range(0, 7)); hwrite = 1'($urandom_range(0, 1));
      end
      if (dp >= 0) hwdata = xf_wdata[dp];
      else hwdata = $urandom;
      @(negedge clk);
      cyc++;
      if (sram_ce && !sram_we) rd_issue_q.push_back(sram_addr);
      if (sram_ce && sram_we) begin
        wr_addr_q.push_back(sram_addr);
        wr_be_q.push_back(sram_be);
      end
      if (hready) begin
        if (dp >= 0) begin
          res_rdata[dp] = hrdata; res_resp[dp] = hresp;
          res_waits[dp] = wcnt;   res_wresp[dp] = wresp;
        end
        wcnt = 0; wresp = 1'b0;
        if (presented) begin dp = ap; ap++; gap_done = 1'b0; end
        else begin dp = -1; if (ap < n) gap_done = 1'b1; end
      end else begin
        wcnt++;
        wresp = wresp | hresp;
      end
    end
    checks++;
    if (cyc >= 4000) begin
      errors++;
      $display("FAIL run_xfers_timeout: got %0d cycles, required < 4000", cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hsel = 1'b0; htrans = 2'b00; hsize = 3'b010; haddr = 32'h0;
    hwrite = 1'b0; hwdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut.state_q !== SCR1_AHB_RAM_IDLE || hready !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0 ||
        sram_ce !== 1'b0 || sram_we !== 1'b0 || sram_be !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got st=%0d rdy=%b resp=%b rdata=%h ce=%b we=%b be=%b, required st=0 1 0 0 0 0 0",
               dut.state_q, hready, hresp, hrdata, sram_ce, sram_we, sram_be);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      hsel = 1'($urandom_range(0, 1)); htrans = 2'($urandom_range(0, 1));
      haddr = $urandom; hwrite = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0 || sram_ce !== 1'b0) begin
        errors++;
        $display("FAIL idle_bus c=%0d: got rdy=%b resp=%b rdata=%h ce=%b, required 1 0 0 0",
                 c, hready, hresp, hrdata, sram_ce);
      end
    end
  endtask

  task automatic test_write_byte_read();
    clear_mon();
    set_xf(0, 32'h10, 3'd2, 1'b1, 32'hDEAD_BEEF, 1'b1);
    set_xf(1, 32'h13, 3'd0, 1'b0, 32'h0, 1'b0);
    predict(2);
    run_xfers(2);
    checks++;
    if (wr_be_q.size() != 1 || wr_be_q[0] !== 4'b1111 || wr_addr_q[0] !== 14'd4) begin
      errors++;
      $display("FAIL wr_word_be: got %0d writes, required one write be=1111 addr=4", wr_be_q.size());
    end
    checks++;
    if (res_waits[1] !== 1) begin
      errors++; $display("FAIL raw_wait: got %0d, required 1", res_waits[1]);
    end
    checks++;
    if (res_rdata[1][31:24] !== 8'hDE || res_rdata[1] !== exp_rdata[1] || res_resp[1] !== 1'b0) begin
      errors++;
      $display("FAIL raw_data: got %h resp=%b, required %h resp=0", res_rdata[1], res_resp[1], exp_rdata[1]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) set_xf(i, 32'(4*i), 3'd2, 1'b1, $urandom, 1'b0);
    predict(4);
    run_xfers(4);
    clear_mon();
    for (int i = 0; i < 4; i++) set_xf(i, 32'(4*i), 3'd2, 1'b0, 32'h0, (i == 0));
    predict(4);
    run_xfers(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_waits[i] !== 0 || res_rdata[i] !== exp_rdata[i] || res_resp[i] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_read %0d: got waits=%0d data=%h resp=%b, required 0 %h 0",
                 i, res_waits[i], res_rdata[i], res_resp[i], exp_rdata[i]);
      end
    end
    checks++;
    if (rd_issue_q.size() != 4) begin
      errors++; $display("FAIL b2b_issue_count: got %0d, required 4", rd_issue_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_issue_q[i] !== AW'(i)) begin
          errors++; $display("FAIL b2b_sram_addr %0d: got %0d, required %0d", i, rd_issue_q[i], i);
        end
      end
    end
  endtask

  task automatic test_halfword_write();
    clear_mon();
    set_xf(0, 32'h20, 3'd2, 1'b1, $urandom, 1'b1);
    set_xf(1, 32'h22, 3'd1, 1'b1, 32'h1234_0000, 1'b0);
    set_xf(2, 32'h20, 3'd2, 1'b0, 32'h0, 1'b0);
    predict(3);
    run_xfers(3);
    checks++;
    if (wr_be_q.size() != 2 || wr_be_q[1] !== 4'b1100 || wr_addr_q[1] !== 14'd8) begin
      errors++; $display("FAIL half_be: got %0d writes, required 2 with last be=1100 addr=8", wr_be_q.size());
    end
    checks++;
    if (res_rdata[2] !== exp_rdata[2] || res_rdata[2][31:16] !== 16'h1234 || res_waits[2] !== 1) begin
      errors++;
      $display("FAIL half_merge: got %h waits=%0d, required %h waits=1", res_rdata[2], res_waits[2], exp_rdata[2]);
    end
  endtask

  task automatic test_errors();
    clear_mon();
    set_xf(0, 32'h0001_0000, 3'd2, 1'b0, 32'h0, 1'b1);
    set_xf(1, 32'h0000_0006, 3'd2, 1'b0, 32'h0, 1'b0);
    set_xf(2, 32'h0000_0005, 3'd1, 1'b1, $urandom, 1'b0);
    set_xf(3, 32'h0000_0000, 3'd3, 1'b0, 32'h0, 1'b0);
    set_xf(4, 32'h0000_0030, 3'd2, 1'b1, 32'hA5A5_5A5A, 1'b0);
    set_xf(5, 32'hFFFC_0000, 3'd2, 1'b1, $urandom, 1'b0);
    set_xf(6, 32'h0000_FFFC, 3'd2, 1'b0, 32'h0, 1'b0);
    set_xf(7, 32'hFFFF_FFFF, 3'd0, 1'b0, 32'h0, 1'b0);
    predict(8);
    run_xfers(8);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res_resp[i] !== exp_err[i] || res_waits[i] !== exp_waits[i] || res_wresp[i] !== exp_err[i] ||
          (exp_known[i] && res_rdata[i] !== exp_rdata[i])) begin
        errors++;
        $display("FAIL err_xfer %0d: got resp=%b waits=%0d wresp=%b data=%h, required %b %0d %b %h",
                 i, res_resp[i], res_waits[i], res_wresp[i], res_rdata[i],
                 exp_err[i], exp_waits[i], exp_err[i], exp_rdata[i]);
      end
    end
    checks++;
    if (wr_addr_q.size() != 1 || rd_issue_q.size() != 1 || wr_addr_q[0] !== 14'd12 || rd_issue_q[0] !== 14'h3FFF) begin
      errors++;
      $display("FAIL err_no_sram: got %0d writes %0d reads, required 1 write @12 and 1 read @3fff",
               wr_addr_q.size(), rd_issue_q.size());
    end
  endtask

  task automatic test_reset_mid_write();
    set_xf(0, 32'h40, 3'd2, 1'b1, 32'h1111_1111, 1'b1);
    predict(1);
    run_xfers(1);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = SCR1_HTRANS_NONSEQ; haddr = 32'h40; hsize = 3'd2; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h2222_2222;
    @(negedge clk);
    checks++;
    if (sram_ce !== 1'b1 || sram_we !== 1'b1) begin
      errors++; $display("FAIL rst_wr_active: got ce=%b we=%b, required 1 1", sram_ce, sram_we);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (sram_ce !== 1'b0 || sram_we !== 1'b0 || hready !== 1'b1) begin
      errors++; $display("FAIL rst_async: got ce=%b we=%b rdy=%b, required 0 0 1", sram_ce, sram_we, hready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (dut.state_q !== SCR1_AHB_RAM_IDLE) begin
      errors++; $display("FAIL rst_state: got %0d, required 0", dut.state_q);
    end
    rst_n = 1'b1;
    set_xf(0, 32'h40, 3'd2, 1'b0, 32'h0, 1'b1);
    predict(1);
    run_xfers(1);
    checks++;
    if (res_rdata[0] !== 32'h1111_1111 || res_rdata[0] !== exp_rdata[0]) begin
      errors++; $display("FAIL rst_dropped_write: got %h, required 11111111", res_rdata[0]);
    end
  endtask

  task automatic test_random();
    int n, r;
    logic [31:0] a;
    for (int i = 0; i < 16; i++) set_xf(i, 32'(4*i), 3'd2, 1'b1, $urandom, 1'($urandom_range(0, 1)));
    predict(16);
    run_xfers(16);
    n = 150;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0) a = 32'(MEM_SIZE) + 32'($urandom_range(0, 255));
      else if (r == 1) a = $urandom;
      else a = 32'($urandom_range(0, 63));
      set_xf(i, a, ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0));
    end
    predict(n);
    run_xfers(n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (res_resp[i] !== exp_err[i] || res_waits[i] !== exp_waits[i] || res_wresp[i] !== exp_err[i] ||
          (exp_known[i] && res_rdata[i] !== exp_rdata[i])) begin
        errors++;
        $display("FAIL rand_xfer %0d a=%h sz=%0d w=%b: got resp=%b waits=%0d wresp=%b data=%h, required %b %0d %b %h",
                 i, xf_addr[i], xf_size[i], xf_write[i], res_resp[i], res_waits[i], res_wresp[i],
                 res_rdata[i], exp_err[i], exp_waits[i], exp_err[i], exp_rdata[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_byte_read();
    test_back_to_back();
    test_halfword_write();
    test_errors();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
